// File: rtl/fsk_demod.sv
// rtl/fsk_demod.sv - FSK receiver: rise-to-rise period classifier, carrier detect and bit timing recovery
// Decodes one bit per BIT_CYCLES from a tone-filtered period measurement.
module fsk_demod #(
  parameter int CNT_W      = 10,
  parameter int THRESH     = 24,
  parameter int BIT_CYCLES = 256,
  parameter int TIMEOUT    = 128,
  parameter bit MARK_FAST  = 1'b1
) (
  input  logic RX_CLK,
  input  logic RESET,
  input  logic FSK_IN,
  output logic RX_DATA,
  output logic RX_VALID,
  output logic CARRIER
);

  localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] THRESH_C  = CNT_W'(THRESH);
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(BIT_CYCLES - 1);
  localparam logic [CNT_W-1:0] SAMPLE_PT = CNT_W'(BIT_CYCLES / 2 - 1);

  typedef enum logic {IDLE, TRACK} state_t;

  state_t           state;
  logic             s1, s2, s3;
  logic [CNT_W-1:0] per_cnt;
  logic [CNT_W-1:0] bit_cnt;
  logic [CNT_W-1:0] period;
  logic [2:0]       good_cnt;
  logic             have_prev;
  logic             last_cand;
  logic             tone;
  logic             tchg;
  logic             rise;
  logic             timeout;
  logic             capture;
  logic             cand;
  logic             bit_val;

  always_comb begin
    rise    = s2 & ~s3;
    timeout = (per_cnt == TIMEOUT_C);
    capture = rise & have_prev & (per_cnt < TIMEOUT_C);
    period  = per_cnt + 1'b1;
    cand    = (period < THRESH_C);
    bit_val = MARK_FAST ? tone : ~tone;
  end

  always_ff @(posedge RX_CLK or posedge RESET) begin
    if (RESET) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= FSK_IN;
      s2 <= s1;
      s3 <= s2;
    end
  end

  // Period measurement and carrier qualification: four good periods in a row lock the carrier.
  always_ff @(posedge RX_CLK or posedge RESET) begin
    if (RESET) begin
      per_cnt   <= '0;
      have_prev <= 1'b0;
      good_cnt  <= '0;
      CARRIER   <= 1'b0;
    end else begin
      if (rise) begin
        per_cnt <= '0;
      end else if (!timeout) begin
        per_cnt <= per_cnt + 1'b1;
      end
      if (timeout) begin
        have_prev <= rise;
        good_cnt  <= '0;
        CARRIER   <= 1'b0;
      end else if (rise) begin
        have_prev <= 1'b1;
        if (capture) begin
          if (good_cnt != 3'd4) begin
            good_cnt <= good_cnt + 1'b1;
          end
          if (good_cnt >= 3'd3) begin
            CARRIER <= 1'b1;
          end
        end
      end
    end
  end

  // Two agreeing captures are needed to flip the tone, so a lone odd period is ignored.
  always_ff @(posedge RX_CLK or posedge RESET) begin
    if (RESET) begin
      last_cand <= 1'b0;
      tone      <= 1'b0;
      tchg      <= 1'b0;
    end else begin
      tchg <= 1'b0;
      if (capture) begin
        last_cand <= cand;
        if ((cand == last_cand) && (cand != tone)) begin
          tone <= cand;
          tchg <= 1'b1;
        end
      end
    end
  end

  always_ff @(posedge RX_CLK or posedge RESET) begin
    if (RESET) begin
      state    <= IDLE;
      bit_cnt  <= '0;
      RX_DATA  <= 1'b0;
      RX_VALID <= 1'b0;
    end else begin
      RX_VALID <= 1'b0;
      case (state)
        IDLE: begin
          bit_cnt <= '0;
          if (CARRIER && !timeout) begin
            state <= TRACK;
          end
        end
        TRACK: begin
          // Carrier loss leaves on the same edge that clears CARRIER; a tone change realigns.
          if (timeout) begin
            state   <= IDLE;
            bit_cnt <= '0;
          end else if (tchg) begin
            bit_cnt <= '0;
          end else begin
            bit_cnt <= (bit_cnt == BIT_LAST) ? '0 : bit_cnt + 1'b1;
            if (bit_cnt == SAMPLE_PT) begin
              RX_DATA  <= bit_val;
              RX_VALID <= 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fsk_demod.sv
// tb/tb_fsk_demod.sv - self-checking bench for fsk_demod against a cycle-timed behavioural model
`timescale 1ns/1ps
module tb_fsk_demod;

  localparam int THRESH     = 24;
  localparam int BIT_CYCLES = 256;
  localparam int TIMEOUT    = 128;

  logic RX_CLK = 1'b0;
  logic RESET  = 1'b1;
  logic FSK_IN = 1'b0;
  logic rx_data, rx_valid, carrier;
  logic rx_data_n, rx_valid_n, carrier_n;

  fsk_demod #(.CNT_W(10), .THRESH(THRESH), .BIT_CYCLES(BIT_CYCLES), .TIMEOUT(TIMEOUT), .MARK_FAST(1'b1)) dut (
    .RX_CLK(RX_CLK), .RESET(RESET), .FSK_IN(FSK_IN),
    .RX_DATA(rx_data), .RX_VALID(rx_valid), .CARRIER(carrier)
  );

  fsk_demod #(.CNT_W(10), .THRESH(THRESH), .BIT_CYCLES(BIT_CYCLES), .TIMEOUT(TIMEOUT), .MARK_FAST(1'b0)) dut_n (
    .RX_CLK(RX_CLK), .RESET(RESET), .FSK_IN(FSK_IN),
    .RX_DATA(rx_data_n), .RX_VALID(rx_valid_n), .CARRIER(carrier_n)
  );

  always #5 RX_CLK = ~RX_CLK;

  int cyc = 0;
  int checks = 0;
  int failures = 0;

  task automatic chk(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s cycle=%0d actual=%0d expected=%0d", name, cyc, act, exp);
    end
  endtask

  // Model in terms of edge times: per_cnt is the time since the last rise, bit phase is time since the anchor.
  int m_last_rise = 0;
  int m_anchor = 0;
  int m_good = 0;
  bit m_have_prev, m_tone, m_last_cand, m_tchg, m_carrier, m_track, m_valid, m_data, m_data_n;
  bit hist [3];

  always @(posedge RX_CLK) begin : model
    int pc, p;
    bit rise, to, cap, cand;
    cyc++;
    if (RESET) begin
      m_last_rise = cyc; m_anchor = 0; m_good = 0;
      m_have_prev = 0; m_tone = 0; m_last_cand = 0; m_tchg = 0;
      m_carrier = 0; m_track = 0; m_valid = 0; m_data = 0; m_data_n = 0;
      hist[0] = 0; hist[1] = 0; hist[2] = 0;
    end else begin
      pc = cyc - m_last_rise - 1;
      if (pc > TIMEOUT) pc = TIMEOUT;
      to = (pc == TIMEOUT);
      rise = hist[1] && !hist[2];
      if (!m_track) begin
        m_valid = 0;
        if (m_carrier && !to) begin m_track = 1; m_anchor = cyc + 1; end
      end else if (to) begin
        m_track = 0; m_valid = 0;
      end else if (m_tchg) begin
        m_anchor = cyc + 1; m_valid = 0;
      end else if ((cyc - m_anchor) % BIT_CYCLES == BIT_CYCLES / 2 - 1) begin
        m_valid = 1; m_data = m_tone; m_data_n = !m_tone;
      end else begin
        m_valid = 0;
      end
      cap = rise && m_have_prev && !to;
      p = cyc - m_last_rise;
      if (rise) m_last_rise = cyc;
      if (to) begin
        m_carrier = 0; m_good = 0; m_have_prev = rise;
      end else if (rise) begin
        m_have_prev = 1;
        if (cap) begin
          if (m_good >= 3) m_carrier = 1;
          if (m_good < 4) m_good++;
        end
      end
      m_tchg = 0;
      if (cap) begin
        cand = (p < THRESH);
        if (cand == m_last_cand && cand != m_tone) begin m_tone = cand; m_tchg = 1; end
        m_last_cand = cand;
      end
      hist[2] = hist[1]; hist[1] = hist[0]; hist[0] = FSK_IN;
    end
  end

  bit prev_car = 0;
  int car_rise = -1;
  int car_fall = -1;
  int st_cyc[$];
  bit st_dat[$];
  int sn_cyc[$];
  bit sn_dat[$];

  always @(posedge RX_CLK) begin
    #3;
    chk("carrier", carrier, m_carrier);
    chk("rx_valid", rx_valid, m_valid);
    chk("rx_data", rx_data, m_data);
    chk("carrier_n", carrier_n, m_carrier);
    chk("rx_valid_n", rx_valid_n, m_valid);
    chk("rx_data_n", rx_data_n, m_data_n);
    if (rx_valid) begin st_cyc.push_back(cyc); st_dat.push_back(rx_data); end
    if (rx_valid_n) begin sn_cyc.push_back(cyc); sn_dat.push_back(rx_data_n); end
    if (carrier && !prev_car) car_rise = cyc;
    if (!carrier && prev_car) car_fall = cyc;
    prev_car = carrier;
  end

  int rise_log[$];

  task automatic period(int p);
    @(negedge RX_CLK); FSK_IN = 1'b1; rise_log.push_back(cyc + 1);
    repeat (p / 2 - 1) @(negedge RX_CLK);
    @(negedge RX_CLK); FSK_IN = 1'b0;
    repeat (p - p / 2 - 1) @(negedge RX_CLK);
  endtask

  task automatic tone_bit(bit b);
    repeat (b ? 16 : 8) period(b ? 16 : 32);
  endtask

  task automatic idle(int n);
    repeat (n) @(negedge RX_CLK);
  endtask

  bit seq [7] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
  int w_cyc[$];
  bit w_dat[$];
  int wn_cyc[$];
  bit wn_dat[$];
  int start_c, end_c, e_last;
  bit rb;
  int acc, rp;

  task automatic window(int lo, int hi);
    w_cyc.delete(); w_dat.delete(); wn_cyc.delete(); wn_dat.delete();
    foreach (st_cyc[k]) if (st_cyc[k] > lo && st_cyc[k] <= hi) begin
      w_cyc.push_back(st_cyc[k]); w_dat.push_back(st_dat[k]);
    end
    foreach (sn_cyc[k]) if (sn_cyc[k] > lo && sn_cyc[k] <= hi) begin
      wn_cyc.push_back(sn_cyc[k]); wn_dat.push_back(sn_dat[k]);
    end
  endtask

  initial begin
    idle(3);
    RESET = 1'b0;

    // Stuck low: nothing happens.
    idle(1000);
    chk("idle_strobes", st_cyc.size(), 0);
    chk("idle_carrier", carrier, 0);
    chk("idle_rx_data", rx_data, 0);

    // Continuous fast tone.
    rise_log.delete();
    start_c = cyc;
    repeat (60) period(16);
    window(start_c, cyc);
    chk("lock_after_5th_rise", car_rise, rise_log[4] + 2);
    chk("fast_strobes_ge3", int'(w_cyc.size() >= 3), 1);
    if (w_cyc.size() >= 1) chk("first_strobe_offset", w_cyc[0] - car_rise, BIT_CYCLES / 2 + 1);
    for (int k = 0; k < w_cyc.size(); k++) chk("fast_bit", w_dat[k], 1);
    for (int k = 1; k < w_cyc.size(); k++) chk("fast_spacing", w_cyc[k] - w_cyc[k-1], BIT_CYCLES);

    // Bit stream after a slow preamble bit that aligns the bit grid.
    tone_bit(1'b0);
    start_c = cyc;
    foreach (seq[k]) tone_bit(seq[k]);
    end_c = cyc;
    repeat (4) period(16);
    window(start_c, end_c);
    chk("stream_count", w_cyc.size(), 7);
    chk("stream_count_n", wn_cyc.size(), 7);
    if (w_cyc.size() == 7) begin
      for (int k = 0; k < 7; k++) chk("stream_bit", w_dat[k], seq[k]);
      chk("stream_gap_11", w_cyc[3] - w_cyc[2], BIT_CYCLES);
      chk("stream_gap_00", w_cyc[5] - w_cyc[4], BIT_CYCLES);
    end
    if (wn_cyc.size() == 7) for (int k = 0; k < 7; k++) chk("stream_bit_n", wn_dat[k], !seq[k]);

    // One odd slow period inside a fast stream.
    start_c = cyc;
    repeat (20) period(16);
    period(32);
    repeat (30) period(16);
    window(start_c, cyc);
    chk("odd_strobes_ge3", int'(w_cyc.size() >= 3), 1);
    for (int k = 0; k < w_cyc.size(); k++) chk("odd_bit", w_dat[k], 1);
    for (int k = 1; k < w_cyc.size(); k++) chk("odd_spacing", w_cyc[k] - w_cyc[k-1], BIT_CYCLES);

    // Input stuck low mid-bit: carrier drops TIMEOUT+1 edges after the synced last rise.
    repeat (5) period(16);
    e_last = rise_log[rise_log.size() - 1];
    idle(300);
    chk("carrier_fall", car_fall, e_last + 2 + TIMEOUT + 1);
    window(car_fall - 1, cyc);
    chk("no_strobe_after_loss", w_cyc.size(), 0);
    chk("hold_rx_data", rx_data, 1);
    chk("hold_rx_data_n", rx_data_n, 0);
    chk("lost_carrier", carrier, 0);

    // Reset pulse in the low half of a fast period.
    repeat (12) period(16);
    @(negedge RX_CLK); FSK_IN = 1'b1;
    repeat (7) @(negedge RX_CLK);
    @(negedge RX_CLK); FSK_IN = 1'b0; RESET = 1'b1;
    repeat (3) begin
      #1;
      chk("rst_carrier", carrier, 0);
      chk("rst_valid", rx_valid, 0);
      chk("rst_data", rx_data, 0);
      chk("rst_data_n", rx_data_n, 0);
      @(negedge RX_CLK);
    end
    RESET = 1'b0;
    idle(4);
    rise_log.delete();
    car_rise = -1;
    repeat (30) period(16);
    chk("relock_after_5th_rise", car_rise, rise_log[4] + 2);

    // Random tones, lone odd periods and occasional carrier gaps.
    for (int i = 0; i < 40; i++) begin
      rb = 1'($urandom_range(1, 0));
      acc = 0;
      while (acc < BIT_CYCLES) begin
        rp = rb ? int'($urandom_range(20, 12)) : int'($urandom_range(40, 28));
        if ($urandom_range(19, 0) == 0) rp = rb ? int'($urandom_range(40, 28)) : int'($urandom_range(20, 12));
        period(rp);
        acc += rp;
      end
      if ($urandom_range(24, 0) == 0) idle(int'($urandom_range(200, 100)));
    end
    idle(50);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
